// File: rtl/pla_stim_pkg.sv
// Shared types and constants for the PLA stimulus generator: FSM states,
// LFSR tap mask and next-state function, and switching-activity counter limits.
package pla_stim_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int LFSR_W = 15;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 15'h6000;

   localparam int TOGGLE_W = 20;
   localparam logic [TOGGLE_W-1:0] TOGGLE_MAX = 20'hFFFFF;

   // x^15 + x^14 + 1 Fibonacci form: shift left, feed back the XOR of the tapped bits.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/pla_popcount.sv
// Combinational population count of an IN_W-bit vector (IN_W <= 15).
module pla_popcount #(
   parameter int IN_W = 15
) (
   input  logic [IN_W-1:0] data,
   output logic [3:0]      count
);

   always_comb begin
      count = 4'd0;
      for (int i = 0; i < IN_W; i++) begin
         count = count + {3'd0, data[i]};
      end
   end

endmodule

// File: rtl/pla_stim_gen.sv
// LFSR-based stimulus transmitter with valid/ready output.
// Define PLA_STIM_TOGGLE_CNT_EN to build the Hamming-distance activity accumulator.
module pla_stim_gen
   import pla_stim_pkg::*;
#(
   parameter int                IN_W    = 15,
   parameter logic [IN_W-1:0]   SEED    = 15'h0001,
   parameter int                NUM_VEC = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                vec_valid,
   input  logic                vec_ready,
   output logic [IN_W-1:0]     vec_data,
   output logic [15:0]         vec_idx,
   output logic [TOGGLE_W-1:0] toggle_cnt
);

   // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
   localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
   localparam logic [15:0]     LAST_IDX = 16'(NUM_VEC - 1);

   state_t          state;
   logic [IN_W-1:0] lfsr;
   logic            xfer;
   logic            load;

   assign xfer     = (state == RUN) && vec_valid && vec_ready;
   assign load     = (state == IDLE) && start;
   assign vec_data = lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lfsr      <= '0;
         vec_idx   <= '0;
         vec_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  lfsr      <= SEED_EFF;
                  vec_idx   <= '0;
                  vec_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               // Completion of the final vector wins over a coincident abort.
               if (xfer) begin
                  lfsr <= lfsr_next(lfsr);
                  if (vec_idx == LAST_IDX) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     vec_valid <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     vec_idx <= vec_idx + 16'd1;
                     if (abort) begin
                        state     <= IDLE;
                        vec_valid <= 1'b0;
                        busy      <= 1'b0;
                     end
                  end
               end else if (abort) begin
                  state     <= IDLE;
                  vec_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               vec_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef PLA_STIM_TOGGLE_CNT_EN
   logic [IN_W-1:0]   prev;
   logic [IN_W-1:0]   diff;
   logic [3:0]        pop;
   logic [TOGGLE_W:0] toggle_sum;

   assign diff = lfsr ^ prev;

   pla_popcount #(
      .IN_W (IN_W)
   ) u_popcount (
      .data  (diff),
      .count (pop)
   );

   // One spare bit catches overflow; the accumulator then pins at its maximum.
   assign toggle_sum = {1'b0, toggle_cnt} + {{(TOGGLE_W-3){1'b0}}, pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev       <= '0;
         toggle_cnt <= '0;
      end else if (load) begin
         prev       <= '0;
         toggle_cnt <= '0;
      end else if (xfer) begin
         prev       <= lfsr;
         toggle_cnt <= toggle_sum[TOGGLE_W] ? TOGGLE_MAX : toggle_sum[TOGGLE_W-1:0];
      end
   end
`else
   assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_pla_stim_gen.sv
// Directed bench for pla_stim_gen: four instances with different SEED/NUM_VEC
// driven from a vector table, plus full-period and mid-run reset sequences.
module tb_pla_stim_gen;

`ifdef PLA_STIM_TOGGLE_CNT_EN
   localparam bit TGL_EN = 1'b1;
`else
   localparam bit TGL_EN = 1'b0;
`endif

   typedef struct {
      string       name;
      int          dut;
      logic        start;
      logic        abort;
      logic        ready;
      logic        ev;
      logic        eb;
      logic        ed;
      logic [14:0] edata;
      logic [15:0] eidx;
      logic [19:0] etc;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        start [4];
   logic        abort [4];
   logic        ready [4];
   logic        busy  [4];
   logic        done  [4];
   logic        valid [4];
   logic [14:0] data  [4];
   logic [15:0] idx   [4];
   logic [19:0] tcnt  [4];

   int vectors;
   int miscompares;
   vec_t vecs[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pla_stim_gen #(.IN_W(15), .SEED(15'h0001), .NUM_VEC(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .busy(busy[0]),
      .done(done[0]), .vec_valid(valid[0]), .vec_ready(ready[0]), .vec_data(data[0]),
      .vec_idx(idx[0]), .toggle_cnt(tcnt[0]));

   pla_stim_gen #(.IN_W(15), .SEED(15'h2000), .NUM_VEC(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .busy(busy[1]),
      .done(done[1]), .vec_valid(valid[1]), .vec_ready(ready[1]), .vec_data(data[1]),
      .vec_idx(idx[1]), .toggle_cnt(tcnt[1]));

   pla_stim_gen #(.IN_W(15), .SEED(15'h0000), .NUM_VEC(32767)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .busy(busy[2]),
      .done(done[2]), .vec_valid(valid[2]), .vec_ready(ready[2]), .vec_data(data[2]),
      .vec_idx(idx[2]), .toggle_cnt(tcnt[2]));

   pla_stim_gen #(.IN_W(15), .SEED(15'h0001), .NUM_VEC(1024)) dut_d (
      .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort[3]), .busy(busy[3]),
      .done(done[3]), .vec_valid(valid[3]), .vec_ready(ready[3]), .vec_data(data[3]),
      .vec_idx(idx[3]), .toggle_cnt(tcnt[3]));

   function automatic logic [19:0] tExp(input int unsigned t);
      return TGL_EN ? ((t > 32'hFFFFF) ? 20'hFFFFF : 20'(t)) : 20'd0;
   endfunction

   function automatic void addVec(input string name, input int d, input logic s, input logic a,
                                  input logic r, input logic ev, input logic eb, input logic ed,
                                  input logic [14:0] edata, input logic [15:0] eidx,
                                  input int unsigned t);
      vec_t v;
      v.name = name; v.dut = d; v.start = s; v.abort = a; v.ready = r;
      v.ev = ev; v.eb = eb; v.ed = ed; v.edata = edata; v.eidx = eidx; v.etc = tExp(t);
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input int d, input logic ev, input logic eb,
                              input logic ed, input logic [14:0] edata, input logic [15:0] eidx,
                              input logic [19:0] etc);
      logic [53:0] act;
      logic [53:0] exp;
      act = {valid[d], busy[d], done[d], data[d], idx[d], tcnt[d]};
      exp = {ev, eb, ed, edata, eidx, etc};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got valid=%b busy=%b done=%b data=%h idx=%0d tcnt=%0d, want valid=%b busy=%b done=%b data=%h idx=%0d tcnt=%0d",
                  name, valid[d], busy[d], done[d], data[d], idx[d], tcnt[d],
                  ev, eb, ed, edata, eidx, etc);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      start[v.dut] = v.start;
      abort[v.dut] = v.abort;
      ready[v.dut] = v.ready;
      @(posedge clk);
      #1;
      checkOutput(v.name, v.dut, v.ev, v.eb, v.ed, v.edata, v.eidx, v.etc);
   endtask

   initial begin
      bit          seen [0:32767];
      int          bad;
      int unsigned acc;
      logic [14:0] prevv;
      logic [14:0] lastv;

      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         start[i] = 1'b0; abort[i] = 1'b0; ready[i] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) checkOutput($sformatf("reset_%0d", i), i, 0, 0, 0, 15'h0, 16'd0, 20'd0);
      rst_n = 1'b1;

      // Instance A: SEED=1, four vectors back to back
      addVec("a_idle",  0, 0, 0, 0, 0, 0, 0, 15'h0000, 0, 0);
      addVec("a_start", 0, 1, 0, 1, 1, 1, 0, 15'h0001, 0, 0);
      addVec("a_v1",    0, 0, 0, 1, 1, 1, 0, 15'h0002, 1, 1);
      addVec("a_v2",    0, 0, 0, 1, 1, 1, 0, 15'h0004, 2, 3);
      addVec("a_v3",    0, 0, 0, 1, 1, 1, 0, 15'h0008, 3, 5);
      addVec("a_done",  0, 0, 0, 1, 0, 0, 1, 15'h0010, 3, 7);
      addVec("a_idle2", 0, 0, 0, 1, 0, 0, 0, 15'h0010, 3, 7);
      // Instance B: SEED=0x2000, two vectors, then abort coinciding with a transfer
      addVec("b_start",      1, 1, 0, 1, 1, 1, 0, 15'h2000, 0, 0);
      addVec("b_v1",         1, 0, 0, 1, 1, 1, 0, 15'h4001, 1, 1);
      addVec("b_done",       1, 0, 0, 1, 0, 0, 1, 15'h0003, 1, 4);
      addVec("b_idle",       1, 0, 0, 1, 0, 0, 0, 15'h0003, 1, 4);
      addVec("b_restart",    1, 1, 0, 1, 1, 1, 0, 15'h2000, 0, 0);
      addVec("b_abort_xfer", 1, 0, 1, 1, 0, 0, 0, 15'h4001, 1, 1);
      addVec("b_post_abort", 1, 0, 0, 0, 0, 0, 0, 15'h4001, 1, 1);
      // Instance D: stall, start-in-run ignored, abort without transfer, restart
      addVec("d_start",       3, 1, 0, 0, 1, 1, 0, 15'h0001, 0, 0);
      addVec("d_stall1",      3, 0, 0, 0, 1, 1, 0, 15'h0001, 0, 0);
      addVec("d_stall2",      3, 0, 0, 0, 1, 1, 0, 15'h0001, 0, 0);
      addVec("d_stall3",      3, 0, 0, 0, 1, 1, 0, 15'h0001, 0, 0);
      addVec("d_start_run",   3, 1, 0, 0, 1, 1, 0, 15'h0001, 0, 0);
      addVec("d_x0",          3, 0, 0, 1, 1, 1, 0, 15'h0002, 1, 1);
      addVec("d_hold",        3, 0, 0, 0, 1, 1, 0, 15'h0002, 1, 1);
      addVec("d_x1",          3, 0, 0, 1, 1, 1, 0, 15'h0004, 2, 3);
      addVec("d_x2",          3, 0, 0, 1, 1, 1, 0, 15'h0008, 3, 5);
      addVec("d_x3",          3, 0, 0, 1, 1, 1, 0, 15'h0010, 4, 7);
      addVec("d_x4",          3, 0, 0, 1, 1, 1, 0, 15'h0020, 5, 9);
      addVec("d_abort",       3, 0, 1, 0, 0, 0, 0, 15'h0020, 5, 9);
      addVec("d_after_abort", 3, 0, 0, 0, 0, 0, 0, 15'h0020, 5, 9);
      addVec("d_abort_idle",  3, 0, 1, 0, 0, 0, 0, 15'h0020, 5, 9);
      addVec("d_restart",     3, 1, 0, 0, 1, 1, 0, 15'h0001, 0, 0);
      addVec("d_rs_x0",       3, 0, 0, 1, 1, 1, 0, 15'h0002, 1, 1);
      addVec("d_rs_x1",       3, 0, 0, 1, 1, 1, 0, 15'h0004, 2, 3);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Asynchronous reset in the middle of D's run, checked before the next edge
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("d_async_reset", 3, 0, 0, 0, 15'h0, 16'd0, 20'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready[3] = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("d_after_reset", 3, 0, 0, 0, 15'h0, 16'd0, 20'd0);

      // Instance C: SEED=0 promoted to 1, full LFSR period
      for (int i = 0; i < 32768; i++) seen[i] = 1'b0;
      start[2] = 1'b1;
      ready[2] = 1'b1;
      @(posedge clk);
      #1;
      start[2] = 1'b0;
      checkOutput("c_first", 2, 1, 1, 0, 15'h0001, 16'd0, 20'd0);
      bad = 0;
      acc = 0;
      prevv = 15'h0;
      lastv = 15'h0;
      for (int i = 0; i < 32767; i++) begin
         if (!valid[2] || data[2] == 15'h0 || seen[data[2]]) bad++;
         seen[data[2]] = 1'b1;
         acc += $countones(data[2] ^ prevv);
         prevv = data[2];
         lastv = data[2];
         @(posedge clk);
         #1;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("[TB] FAIL c_distinct: got %0d repeated/zero/invalid vectors, want 0", bad);
      end
      vectors++;
      if (lastv !== 15'h4000) begin
         miscompares++;
         $display("[TB] FAIL c_last_vec: got %h, want 4000", lastv);
      end
      checkOutput("c_done", 2, 0, 0, 1, 15'h0001, 16'd32766, tExp(acc));
      @(posedge clk);
      #1;
      checkOutput("c_idle", 2, 0, 0, 0, 15'h0001, 16'd32766, tExp(acc));
      start[2] = 1'b1;
      ready[2] = 1'b0;
      @(posedge clk);
      #1;
      start[2] = 1'b0;
      checkOutput("c_rerun_first", 2, 1, 1, 0, 15'h0001, 16'd0, 20'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
